// File: rtl/pifo_calendar_ctrl.sv
// Sequencer for a linear pifo calendar chain: arbitrates insert / pop / CPU slot writes,
// drives the shared atom control lines one cycle after acceptance and returns popped heads.
module pifo_calendar_ctrl #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int DEPTH         = 16,
    parameter int IDX_WIDTH     = 4,
    parameter int CNT_WIDTH     = 5,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_ins_valid,
    output logic                     out_ins_ready,
    input  logic [ELEMENT_WIDTH-1:0] in_ins_data,
    input  logic                     in_pop_req,
    output logic                     out_pop_ready,
    output logic                     out_pop_valid,
    output logic [ELEMENT_WIDTH-1:0] out_pop_data,
    input  logic                     in_cpu_req,
    input  logic [IDX_WIDTH-1:0]     in_cpu_idx,
    input  logic [ELEMENT_WIDTH-1:0] in_cpu_data,
    output logic                     out_cpu_ack,
    output logic                     out_ctl_insert,
    output logic                     out_ctl_pop,
    output logic [ELEMENT_WIDTH-1:0] out_pifo_input,
    output logic [ELEMENT_WIDTH-1:0] out_cpu_data,
    output logic [DEPTH-1:0]         out_cpu_insert_vec,
    input  logic [ELEMENT_WIDTH-1:0] in_head_element,
    output logic [CNT_WIDTH-1:0]     out_count,
    output logic [15:0]              out_drop_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                     run_q, run_d;
    logic [CNT_WIDTH-1:0]     count_q, count_d;
    logic [SW-1:0]            starve_q, starve_d;
    logic [15:0]              drop_q, drop_d;
    logic                     ctl_insert_q, ctl_insert_d;
    logic                     ctl_pop_q, ctl_pop_d;
    logic [ELEMENT_WIDTH-1:0] pifo_input_q, pifo_input_d;
    logic [ELEMENT_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic [DEPTH-1:0]         cpu_vec_q, cpu_vec_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     pop_valid_q, pop_valid_d;
    logic [ELEMENT_WIDTH-1:0] pop_data_q, pop_data_d;

    logic cpu_block, ins_acc, pop_acc, ins_issue, cpu_acc;

    // run_q keeps both readies low while in reset and for the first edge after release
    assign cpu_block     = (starve_q == SW'(STARVE_LIMIT));
    assign out_pop_ready = run_q & (count_q != '0) & ~cpu_block;
    assign out_ins_ready = run_q & ((count_q < CNT_WIDTH'(DEPTH)) | (in_pop_req & out_pop_ready))
                           & ~cpu_block;

    assign ins_acc   = in_ins_valid & out_ins_ready;
    assign pop_acc   = in_pop_req & out_pop_ready;
    assign ins_issue = ins_acc & in_ins_data[ELEMENT_WIDTH-1];
    assign cpu_acc   = in_cpu_req & ~ins_acc & ~pop_acc;

    always_comb begin
        run_d   = 1'b1;
        count_d = count_q;
        case ({ins_issue, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        starve_d = '0;
        if (in_cpu_req && !cpu_acc)
            starve_d = starve_q + 1'b1;

        drop_d = drop_q;
        if (ins_acc && !in_ins_data[ELEMENT_WIDTH-1] && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;

        ctl_insert_d = ins_issue;
        ctl_pop_d    = pop_acc;
        pifo_input_d = ins_issue ? in_ins_data : '0;
        cpu_ack_d    = cpu_acc;
        cpu_data_d   = cpu_acc ? in_cpu_data : '0;
        // out-of-range indices shift the strobe off the end, giving an all-zero vector
        cpu_vec_d    = cpu_acc ? (DEPTH'(1) << in_cpu_idx) : '0;

        pop_valid_d  = ctl_pop_q;
        pop_data_d   = ctl_pop_q ? in_head_element : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q        <= 1'b0;
            count_q      <= '0;
            starve_q     <= '0;
            drop_q       <= '0;
            ctl_insert_q <= 1'b0;
            ctl_pop_q    <= 1'b0;
            pifo_input_q <= '0;
            cpu_data_q   <= '0;
            cpu_vec_q    <= '0;
            cpu_ack_q    <= 1'b0;
            pop_valid_q  <= 1'b0;
            pop_data_q   <= '0;
        end else begin
            run_q        <= run_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            drop_q       <= drop_d;
            ctl_insert_q <= ctl_insert_d;
            ctl_pop_q    <= ctl_pop_d;
            pifo_input_q <= pifo_input_d;
            cpu_data_q   <= cpu_data_d;
            cpu_vec_q    <= cpu_vec_d;
            cpu_ack_q    <= cpu_ack_d;
            pop_valid_q  <= pop_valid_d;
            pop_data_q   <= pop_data_d;
        end
    end

    assign out_count          = count_q;
    assign out_drop_cnt       = drop_q;
    assign out_ctl_insert     = ctl_insert_q;
    assign out_ctl_pop        = ctl_pop_q;
    assign out_pifo_input     = pifo_input_q;
    assign out_cpu_data       = cpu_data_q;
    assign out_cpu_insert_vec = cpu_vec_q;
    assign out_cpu_ack        = cpu_ack_q;
    assign out_pop_valid      = pop_valid_q;
    assign out_pop_data       = pop_data_q;

endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// Bench for pifo_calendar_ctrl: behavioural atom chain plus an accept-time reference
// queue feeding a scoreboard of expected pop results and their arrival cycles.
module tb_pifo_calendar_ctrl;
    localparam int EW = 32;
    localparam int DEPTH = 16;
    localparam int IW = 4;
    localparam int CW = 5;
    localparam int SL = 8;

    logic          clk, rstn;
    logic          in_ins_valid, out_ins_ready;
    logic [EW-1:0] in_ins_data;
    logic          in_pop_req, out_pop_ready, out_pop_valid;
    logic [EW-1:0] out_pop_data;
    logic          in_cpu_req, out_cpu_ack;
    logic [IW-1:0] in_cpu_idx;
    logic [EW-1:0] in_cpu_data;
    logic          out_ctl_insert, out_ctl_pop;
    logic [EW-1:0] out_pifo_input, out_cpu_data, in_head_element;
    logic [DEPTH-1:0] out_cpu_insert_vec;
    logic [CW-1:0] out_count;
    logic [15:0]   out_drop_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { logic [EW-1:0] d; int c; } sb_t;
    sb_t sb[$];
    logic [EW-1:0] refq [DEPTH];
    logic [EW-1:0] mem  [DEPTH];

    pifo_calendar_ctrl #(.ELEMENT_WIDTH(EW), .DEPTH(DEPTH), .IDX_WIDTH(IW),
                         .CNT_WIDTH(CW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rstn(rstn),
        .in_ins_valid(in_ins_valid), .out_ins_ready(out_ins_ready), .in_ins_data(in_ins_data),
        .in_pop_req(in_pop_req), .out_pop_ready(out_pop_ready),
        .out_pop_valid(out_pop_valid), .out_pop_data(out_pop_data),
        .in_cpu_req(in_cpu_req), .in_cpu_idx(in_cpu_idx), .in_cpu_data(in_cpu_data),
        .out_cpu_ack(out_cpu_ack), .out_ctl_insert(out_ctl_insert), .out_ctl_pop(out_ctl_pop),
        .out_pifo_input(out_pifo_input), .out_cpu_data(out_cpu_data),
        .out_cpu_insert_vec(out_cpu_insert_vec), .in_head_element(in_head_element),
        .out_count(out_count), .out_drop_cnt(out_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sorted chain: smaller rank (bits 30:0) nearer the head, equal ranks keep arrival order
    function automatic int ins_pos(input logic [EW-1:0] a [DEPTH], input logic [EW-1:0] e);
        for (int i = 0; i < DEPTH; i++)
            if (!a[i][EW-1] || a[i][EW-2:0] > e[EW-2:0]) return i;
        return DEPTH;
    endfunction

    // Behavioural atom chain driven only by the DUT control lines
    always @(posedge clk or negedge rstn) begin
        logic [EW-1:0] t [DEPTH];
        int p;
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) t[i] = mem[i];
            if (out_ctl_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) t[i] = t[i+1];
                t[DEPTH-1] = '0;
            end
            if (out_ctl_insert) begin
                p = ins_pos(t, out_pifo_input);
                if (p < DEPTH) begin
                    for (int i = DEPTH - 1; i > p; i--) t[i] = t[i-1];
                    t[p] = out_pifo_input;
                end
            end
            for (int i = 0; i < DEPTH; i++)
                if (out_cpu_insert_vec[i]) t[i] = out_cpu_data;
            for (int i = 0; i < DEPTH; i++) mem[i] <= t[i];
        end
    end
    assign in_head_element = mem[0];

    // Accept-time monitor: reference queue, scoreboard push, and pop result comparison
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int p;
        sb_t s;
        if (!rstn) begin
            sb.delete();
            for (int i = 0; i < DEPTH; i++) refq[i] = '0;
        end else begin
            if (out_cpu_ack && int'(in_cpu_idx) < DEPTH) refq[in_cpu_idx] = in_cpu_data;
            if (out_pop_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got data=%h at cycle %0d, required no pop", out_pop_data, cyc);
                end else begin
                    s = sb.pop_front();
                    if (out_pop_data !== s.d || cyc !== s.c) begin
                        bad++;
                        $display("FAIL pop_result: got data=%h cycle=%0d, required data=%h cycle=%0d",
                                 out_pop_data, cyc, s.d, s.c);
                    end
                end
            end
            if (in_pop_req && out_pop_ready) begin
                e = refq[0];
                for (int i = 0; i < DEPTH - 1; i++) refq[i] = refq[i+1];
                refq[DEPTH-1] = '0;
                s.d = e;
                s.c = cyc + 2;
                sb.push_back(s);
            end
            if (in_ins_valid && out_ins_ready && in_ins_data[EW-1]) begin
                p = ins_pos(refq, in_ins_data);
                if (p < DEPTH) begin
                    for (int i = DEPTH - 1; i > p; i--) refq[i] = refq[i-1];
                    refq[p] = in_ins_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_ins_valid = 0; in_ins_data = '0; in_pop_req = 0;
        in_cpu_req = 0; in_cpu_idx = '0; in_cpu_data = '0;
    endtask

    function automatic logic [EW-1:0] rand_elem();
        return 32'h8000_0000 | (32'($urandom_range(0, 255)) << 12);
    endfunction

    task automatic drain();
        int n = 0;
        in_ins_valid = 0;
        in_pop_req = 1;
        while (out_count != 0 && n < 40) begin
            tick();
            n++;
        end
        in_pop_req = 0;
        total++;
        if (out_count !== 0) begin
            bad++;
            $display("FAIL drain_timeout: got count=%0d, required 0", out_count);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 0;
        repeat (3) tick();
        total++;
        if ({out_ins_ready, out_pop_ready, out_pop_valid, out_cpu_ack, out_ctl_insert, out_ctl_pop,
             out_count, out_drop_cnt, out_cpu_insert_vec, out_pifo_input, out_cpu_data, out_pop_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ins_rdy=%b pop_rdy=%b count=%0d, required all zero",
                     out_ins_ready, out_pop_ready, out_count);
        end
        #3 rstn = 1;
        repeat (2) tick();
        total++;
        if (out_ins_ready !== 1'b1 || out_pop_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready: got ins=%b pop=%b, required ins=1 pop=0",
                     out_ins_ready, out_pop_ready);
        end
    endtask

    task automatic test_basic();
        logic [EW-1:0] v [3];
        v[0] = 32'h8000_5000; v[1] = 32'h8000_3000; v[2] = 32'h8000_9000;
        for (int i = 0; i < 3; i++) begin
            in_ins_valid = 1; in_ins_data = v[i];
            tick();
        end
        in_ins_valid = 0;
        total++;
        if (out_count !== 5'd3) begin
            bad++;
            $display("FAIL basic_count: got %0d, required 3", out_count);
        end
        total++;
        if (refq[0] !== 32'h8000_3000 || refq[1] !== 32'h8000_5000 || refq[2] !== 32'h8000_9000) begin
            bad++;
            $display("FAIL basic_order: got %h %h %h, required 80003000 80005000 80009000",
                     refq[0], refq[1], refq[2]);
        end
        in_pop_req = 1;
        repeat (3) tick();
        in_pop_req = 0;
        repeat (4) tick();
        total++;
        if (out_count !== 5'd0) begin
            bad++;
            $display("FAIL basic_drain_count: got %0d, required 0", out_count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            in_ins_valid = 1; in_ins_data = rand_elem();
            tick();
        end
        in_ins_data = rand_elem();
        total++;
        if (out_count !== 5'd16 || out_ins_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_blocks_insert: got count=%0d ins_rdy=%b, required 16 / 0", out_count, out_ins_ready);
        end
        tick();
        in_pop_req = 1;
        #1;
        total++;
        if (out_ins_ready !== 1'b1 || out_pop_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_unblocks: got ins=%b pop=%b, required 1 / 1", out_ins_ready, out_pop_ready);
        end
        tick();
        in_ins_valid = 0; in_pop_req = 0;
        total++;
        if (out_ctl_insert !== 1'b1 || out_ctl_pop !== 1'b1 || out_count !== 5'd16) begin
            bad++;
            $display("FAIL full_both_issue: got ins=%b pop=%b count=%0d, required 1 1 16",
                     out_ctl_insert, out_ctl_pop, out_count);
        end
        drain();
    endtask

    task automatic test_empty_pop();
        in_pop_req = 1;
        #1;
        total++;
        if (out_pop_ready !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop_ready: got %b, required 0", out_pop_ready);
        end
        tick();
        in_pop_req = 0;
        total++;
        if (out_ctl_pop !== 1'b0 || out_count !== 5'd0) begin
            bad++;
            $display("FAIL empty_pop_issue: got ctl_pop=%b count=%0d, required 0 0", out_ctl_pop, out_count);
        end
    endtask

    task automatic test_drop();
        in_ins_valid = 1; in_ins_data = 32'h0000_4000;
        #1;
        total++;
        if (out_ins_ready !== 1'b1) begin
            bad++;
            $display("FAIL drop_ready: got %b, required 1", out_ins_ready);
        end
        tick();
        in_ins_valid = 0;
        total++;
        if (out_ctl_insert !== 1'b0 || out_drop_cnt !== 16'd1 || out_count !== 5'd0) begin
            bad++;
            $display("FAIL drop_effect: got ctl_ins=%b drop=%0d count=%0d, required 0 1 0",
                     out_ctl_insert, out_drop_cnt, out_count);
        end
    endtask

    task automatic test_cpu_starve();
        int ack_at = 0;
        for (int i = 0; i < 4; i++) begin
            in_ins_valid = 1; in_ins_data = rand_elem();
            tick();
        end
        in_cpu_req = 1; in_cpu_idx = 4'd2; in_cpu_data = 32'h8000_7000;
        in_pop_req = 1; in_ins_data = rand_elem();
        for (int i = 1; i <= SL + 2; i++) begin
            tick();
            in_ins_data = rand_elem();
            if (out_cpu_ack === 1'b1) begin
                ack_at = i;
                in_cpu_req = 0;
                total++;
                if (out_cpu_insert_vec !== 16'h0004 || out_ctl_insert !== 1'b0 || out_ctl_pop !== 1'b0 ||
                    out_cpu_data !== 32'h8000_7000) begin
                    bad++;
                    $display("FAIL cpu_issue: got vec=%h ins=%b pop=%b data=%h, required 0004 0 0 80007000",
                             out_cpu_insert_vec, out_ctl_insert, out_ctl_pop, out_cpu_data);
                end
                break;
            end
        end
        total++;
        if (ack_at !== SL + 1) begin
            bad++;
            $display("FAIL cpu_ack_latency: got cycle %0d, required %0d", ack_at, SL + 1);
        end
        in_cpu_req = 0;
        tick();
        total++;
        if (out_cpu_ack !== 1'b0 || out_cpu_insert_vec !== '0) begin
            bad++;
            $display("FAIL cpu_ack_pulse: got ack=%b vec=%h, required 0 0000", out_cpu_ack, out_cpu_insert_vec);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            in_ins_valid = 1; in_ins_data = rand_elem();
            tick();
        end
        in_ins_valid = 0;
        in_pop_req = 1;
        tick();
        in_pop_req = 0;
        #2 rstn = 0;
        #1;
        total++;
        if ({out_ins_ready, out_pop_ready, out_pop_valid, out_cpu_ack, out_ctl_insert, out_ctl_pop,
             out_count, out_drop_cnt, out_cpu_insert_vec, out_pifo_input, out_cpu_data, out_pop_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got ctl_pop=%b count=%0d drop=%0d, required all zero",
                     out_ctl_pop, out_count, out_drop_cnt);
        end
        repeat (2) tick();
        #2 rstn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_pop_valid !== 1'b0 || out_count !== 5'd0) begin
                bad++;
                $display("FAIL reset_mid_stale: got pop_valid=%b count=%0d, required 0 0", out_pop_valid, out_count);
            end
        end
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_empty_pop();
        test_drop();
        test_cpu_starve();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending pops, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end
endmodule
